// File: rtl/sonar_frame_tx_if.sv
// Byte stream from the sonar framer to the UART transmitter.
// Latency: wires only, no storage.
// Backpressure: a byte moves on a cycle where tx_data_valid && tx_data_ready.
//
// Signals:
//   tx_data        byte offered to uart_tx
//   tx_data_valid  tx_data holds a byte to send
//   tx_data_ready  uart_tx can take the byte this cycle
interface sonar_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ready
  );
endinterface

// File: rtl/sonar_frame_tx.sv
// Snapshots four 8-bit distances on a period tick or request and sends an 11-byte framed packet.
// Latency: request in cycle N -> snapshot in N+1 -> header valid in N+2; frame_done in N+13 with ready high.
// Backpressure: tx_data held stable while stalled; one extra request is queued, further ones are counted as overruns.
//
// Ports:
//   i_sys_clk, i_rst_n       clock, synchronous active-low reset
//   i_enable                 lets period ticks start frames (i_send_req always honoured)
//   i_send_req               one-cycle request for an immediate frame
//   i_dist_a..i_dist_d       distances in cm
//   tx                       byte stream to uart_tx (valid/ready)
//   o_busy                   snapshot through acceptance of the tail byte
//   o_frame_done             one-cycle pulse after the tail byte is accepted
//   o_overrun_cnt            dropped requests, saturating at 255
module sonar_frame_tx #(
  parameter int          PERIOD_CYCLES = 100_000_000,
  parameter logic [7:0]  HDR_BYTE      = 8'hAA,
  parameter logic [7:0]  TAIL_BYTE     = 8'h55
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_send_req,
  input  logic [7:0]       i_dist_a,
  input  logic [7:0]       i_dist_b,
  input  logic [7:0]       i_dist_c,
  input  logic [7:0]       i_dist_d,
  sonar_frame_tx_if.master tx,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [7:0]       o_overrun_cnt
);

  localparam int              CW       = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [3:0]      IDX_LAST = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic          r_pending;
  logic [3:0]    r_idx;
  logic [7:0]    r_csum;
  logic [7:0]    r_ovr;
  logic [7:0]    r_snap_a, r_snap_b, r_snap_c, r_snap_d;

  logic          w_tick;
  logic          w_req;
  logic          w_accept;
  logic [7:0]    w_byte;

  // Free-running period counter; keeps counting while ticks are disabled.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick   = (r_cnt == CNT_LAST) && i_enable;
  assign w_req    = w_tick || i_send_req;
  assign w_accept = (r_state == S_SEND) && tx.tx_data_ready;

  // Byte selected by the frame index; all sources are registers, so the
  // offered byte cannot move while the transmitter stalls.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = HDR_BYTE;
      4'd1:    w_byte = 8'h65;
      4'd2:    w_byte = r_snap_a;
      4'd3:    w_byte = 8'h66;
      4'd4:    w_byte = r_snap_b;
      4'd5:    w_byte = 8'h67;
      4'd6:    w_byte = r_snap_c;
      4'd7:    w_byte = 8'h68;
      4'd8:    w_byte = r_snap_d;
      4'd9:    w_byte = r_csum;
      4'd10:   w_byte = TAIL_BYTE;
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_idx     <= 4'd0;
      r_csum    <= 8'h00;
      r_ovr     <= 8'h00;
      r_snap_a  <= 8'h00;
      r_snap_b  <= 8'h00;
      r_snap_c  <= 8'h00;
      r_snap_d  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A queued request is consumed here; a fresh request in the same
          // cycle takes its place in the queue rather than counting as overrun.
          if (r_pending) begin
            r_state   <= S_LOAD;
            r_pending <= w_req;
          end else if (w_req) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_snap_a <= i_dist_a;
          r_snap_b <= i_dist_b;
          r_snap_c <= i_dist_c;
          r_snap_d <= i_dist_d;
          r_csum   <= 8'h00;
          r_idx    <= 4'd0;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_idx == IDX_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 4'd1;
              // Checksum covers the tag/value bytes only.
              if ((r_idx >= 4'd1) && (r_idx <= 4'd8)) begin
                r_csum <= r_csum + w_byte;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Requests arriving while a frame is in flight: queue one, count the rest.
      if ((r_state != S_IDLE) && w_req) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_ovr != 8'hFF) begin
          r_ovr <= r_ovr + 8'd1;
        end
      end
    end
  end

  assign tx.tx_data       = (r_state == S_SEND) ? w_byte : 8'h00;
  assign tx.tx_data_valid = (r_state == S_SEND);
  assign o_busy           = (r_state == S_LOAD) || (r_state == S_SEND);
  assign o_frame_done     = (r_state == S_DONE);
  assign o_overrun_cnt    = r_ovr;

endmodule

// File: tb/tb_sonar_frame_tx.sv
// Randomised self-checking bench for sonar_frame_tx against a frame-level model.
// Latency: checks request-to-done and busy length against the fixed frame timing.
// Backpressure: drives ready always-high, gapped, random and stuck-low.
module tb_sonar_frame_tx;
  localparam int PERIOD = 2000;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       send_req;
  logic [7:0] dist_a, dist_b, dist_c, dist_d;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_cnt;

  sonar_frame_tx_if u_if();

  sonar_frame_tx #(
    .PERIOD_CYCLES (PERIOD),
    .HDR_BYTE      (8'hAA),
    .TAIL_BYTE     (8'h55)
  ) u_dut (
    .i_sys_clk     (sys_clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_send_req    (send_req),
    .i_dist_a      (dist_a),
    .i_dist_b      (dist_b),
    .i_dist_c      (dist_c),
    .i_dist_d      (dist_d),
    .tx            (u_if),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_overrun_cnt (overrun_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ready driver ----------------
  // 0: always ready, 1: low for 5 cycles after each acceptance, 2: random, 3: stuck low
  int   rdy_mode = 0;
  int   low_left = 0;
  logic acc_seen = 1'b0;

  initial begin
    u_if.tx_data_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (rdy_mode)
        1: begin
          if (acc_seen) low_left = 5;
          if (low_left > 0) begin
            u_if.tx_data_ready = 1'b0;
            low_left--;
          end else begin
            u_if.tx_data_ready = 1'b1;
          end
        end
        2:       u_if.tx_data_ready = ($urandom_range(0, 3) != 0);
        3:       u_if.tx_data_ready = 1'b0;
        default: u_if.tx_data_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] got[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_busy  = 1'b0;
  int         busy_run = 0, last_busy_len = 0;
  int         last_start = 0, n_starts = 0;
  int         last_done = 0, n_done = 0;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      acc_seen   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", u_if.tx_data_valid, 1'b1);
        check("hold_dat", u_if.tx_data, prev_data);
      end
      prev_stall = u_if.tx_data_valid && !u_if.tx_data_ready;
      prev_data  = u_if.tx_data;
      acc_seen   = u_if.tx_data_valid && u_if.tx_data_ready;
      if (acc_seen) got.push_back(u_if.tx_data);
    end
    if (busy && !prev_busy) begin
      last_start = cyc;
      n_starts++;
      busy_run = 0;
    end
    if (busy) busy_run++;
    if (frame_done) begin
      last_done     = cyc;
      last_busy_len = busy_run;
      n_done++;
    end
    prev_busy = busy;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int budget = 200;
    while (!u_if.tx_data_valid && budget > 0) begin
      tick(1);
      budget--;
    end
    if (!u_if.tx_data_valid) check({tag, "_wait_vld"}, u_if.tx_data_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int budget = 3000;
    while ((busy || frame_done) && budget > 0) begin
      tick(1);
      budget--;
    end
    if (busy) check({tag, "_wait_idle"}, busy, 1'b0);
    tick(2);
  endtask

  // Reference frame: header, four tag/value pairs, mod-256 sum of those eight bytes, tail.
  task automatic expect_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    logic [7:0] e[11];
    int budget = 4000;
    int sum;
    while (got.size() < 11 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (got.size() < 11) begin
      check({tag, "_timeout"}, got.size(), 11);
      got.delete();
      return;
    end
    sum   = ('h65 + a + 'h66 + b + 'h67 + c + 'h68 + d) % 256;
    e[0]  = 8'hAA;
    e[1]  = 8'h65;  e[2] = a;
    e[3]  = 8'h66;  e[4] = b;
    e[5]  = 8'h67;  e[6] = c;
    e[7]  = 8'h68;  e[8] = d;
    e[9]  = sum[7:0];
    e[10] = 8'h55;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_b%0d", tag, i), got.pop_front(), e[i]);
    end
  endtask

  // ---------------- sequence ----------------
  int         rst_rel, rc, n0, s1;
  logic [7:0] ra, rb, rcc, rd, na, nb, nc, nd;
  logic       extra;

  initial begin
    rst_n = 1'b0; enable = 1'b0; send_req = 1'b0;
    dist_a = 8'h00; dist_b = 8'h00; dist_c = 8'h00; dist_d = 8'h00;
    tick(3);
    check("rst_vld",  u_if.tx_data_valid, 1'b0);
    check("rst_dat",  u_if.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_ovr",  overrun_cnt, 8'h00);
    rst_n = 1'b1;
    tick(3);

    // values, latency and busy length
    dist_a = 8'h10; dist_b = 8'h20; dist_c = 8'h30; dist_d = 8'h40;
    tick(1);
    rc = cyc;
    pulse_req();
    expect_frame("val", 8'h10, 8'h20, 8'h30, 8'h40);
    tick(3);
    check("lat_done", last_done - rc, 13);
    check("busy_len", last_busy_len, 12);
    wait_idle("val");

    // gapped backpressure
    rdy_mode = 1;
    ra = 8'($urandom); rb = 8'($urandom); rcc = 8'($urandom); rd = 8'($urandom);
    dist_a = ra; dist_b = rb; dist_c = rcc; dist_d = rd;
    pulse_req();
    expect_frame("bp", ra, rb, rcc, rd);
    rdy_mode = 0;
    wait_idle("bp");

    // snapshot isolation
    dist_a = 8'h10; dist_b = 8'h20; dist_c = 8'h30; dist_d = 8'h40;
    pulse_req();
    wait_valid("snap");
    dist_b = 8'h99;
    expect_frame("snap1", 8'h10, 8'h20, 8'h30, 8'h40);
    wait_idle("snap1");
    pulse_req();
    expect_frame("snap2", 8'h10, 8'h99, 8'h30, 8'h40);
    wait_idle("snap2");

    // overrun: one queued, two dropped
    rdy_mode = 3;
    tick(1);
    pulse_req();
    wait_valid("ovr");
    tick(2);
    repeat (3) begin
      pulse_req();
      tick(1);
    end
    tick(1);
    check("ovr_cnt2", overrun_cnt, 8'd2);
    rdy_mode = 0;
    expect_frame("ovr_f1", 8'h10, 8'h99, 8'h30, 8'h40);
    expect_frame("ovr_f2", 8'h10, 8'h99, 8'h30, 8'h40);
    tick(40);
    check("ovr_no_third", got.size(), 0);
    check("ovr_idle", busy, 1'b0);
    check("ovr_hold2", overrun_cnt, 8'd2);

    // overrun saturation
    rdy_mode = 3;
    tick(1);
    pulse_req();
    wait_valid("sat");
    repeat (300) begin
      pulse_req();
      tick(1);
    end
    check("ovr_sat", overrun_cnt, 8'hFF);
    rdy_mode = 0;
    expect_frame("sat_f1", 8'h10, 8'h99, 8'h30, 8'h40);
    expect_frame("sat_f2", 8'h10, 8'h99, 8'h30, 8'h40);
    wait_idle("sat");
    check("ovr_sat_hold", overrun_cnt, 8'hFF);

    // reset while byte 5 is on the bus
    got.delete();
    pulse_req();
    begin
      int budget = 100;
      while (got.size() < 5 && budget > 0) begin
        tick(1);
        budget--;
      end
      check("mid_reach5", got.size(), 5);
    end
    rst_n = 1'b0;
    tick(1);
    check("mid_vld",  u_if.tx_data_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_ovr",  overrun_cnt, 8'h00);
    check("mid_done", frame_done, 1'b0);
    rst_n   = 1'b1;
    rst_rel = cyc;
    got.delete();
    tick(2);
    pulse_req();
    expect_frame("post_rst", 8'h10, 8'h99, 8'h30, 8'h40);
    wait_idle("post_rst");

    // periodic ticks aligned to the counter wrap
    dist_a = 8'h01; dist_b = 8'hFE; dist_c = 8'h7F; dist_d = 8'h80;
    enable = 1'b1;
    n0 = n_starts;
    begin
      int budget = PERIOD + 200;
      while (n_starts == n0 && budget > 0) begin
        tick(1);
        budget--;
      end
    end
    check("per_start", n_starts, n0 + 1);
    check("per_phase", (last_start - rst_rel) % PERIOD, 0);
    s1 = last_start;
    expect_frame("per_f1", 8'h01, 8'hFE, 8'h7F, 8'h80);
    begin
      int budget = PERIOD + 200;
      while (n_starts == n0 + 1 && budget > 0) begin
        tick(1);
        budget--;
      end
    end
    check("per_gap", last_start - s1, PERIOD);
    expect_frame("per_f2", 8'h01, 8'hFE, 8'h7F, 8'h80);
    enable = 1'b0;
    wait_idle("per");
    n0 = n_starts;
    tick(PERIOD + 500);
    check("en0_no_tick", n_starts, n0);
    pulse_req();
    expect_frame("en0_req", 8'h01, 8'hFE, 8'h7F, 8'h80);
    wait_idle("en0");

    // random ready, random data, optional queued second frame
    for (int it = 0; it < 8; it++) begin
      rdy_mode = 2;
      ra = 8'($urandom); rb = 8'($urandom); rcc = 8'($urandom); rd = 8'($urandom);
      na = 8'($urandom); nb = 8'($urandom); nc = 8'($urandom); nd = 8'($urandom);
      extra = 1'($urandom_range(0, 1));
      dist_a = ra; dist_b = rb; dist_c = rcc; dist_d = rd;
      pulse_req();
      wait_valid("rnd");
      dist_a = na; dist_b = nb; dist_c = nc; dist_d = nd;
      if (extra) begin
        tick($urandom_range(0, 5));
        if (busy) pulse_req();
        else extra = 1'b0;
      end
      expect_frame($sformatf("rnd%0d_a", it), ra, rb, rcc, rd);
      if (extra) expect_frame($sformatf("rnd%0d_b", it), na, nb, nc, nd);
      rdy_mode = 0;
      wait_idle("rnd");
      check($sformatf("rnd%0d_left", it), got.size(), 0);
    end
    check("rnd_ovr", overrun_cnt, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, observed cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
